pc_sequencer: RTL
=================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter: PC_BITS, 6, width of PC and of the branch-target fields this block controls.
REQ-002 Parameter: CNT_BITS, 16, width of the retired-instruction counter.
REQ-003 clka  input  1  single system clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset; low forces reset state immediately regardless of clka.
REQ-005 start  input  1  level; begins sequencing from IDLE, or resumes it from HALT.
REQ-006 halt_req  input  1  single-cycle pulse; requests a stop at the next instruction boundary.
REQ-007 stall  input  1  instruction memory not ready; holds FETCH.
REQ-008 op_valid  input  1  decoded instruction present on op_kind/cond_true.
REQ-009 op_kind  input  2  00 sequential, 01 conditional branch to imm, 10 jump to sr1_val, 11 halt.
REQ-010 cond_true  input  1  branch condition; meaningful only with op_valid and op_kind=01.
REQ-011 pc_ctl  output  2  PC source select: 00 hold, 01 increment, 10 load imm, 11 load sr1_val.
REQ-012 pc_latch_data  output  1  PC update strobe; PC changes only in a cycle where this is 1.
REQ-013 fetch_en  output  1  instruction-memory read enable.
REQ-014 branch_taken  output  1  1 during an UPDATE cycle whose pc_ctl is 10 or 11.
REQ-015 busy  output  1  1 in every state except IDLE and HALT.
REQ-016 halted  output  1  1 in HALT only.
REQ-017 instr_count  output  CNT_BITS  retired-instruction count (see Configuration).

Function
REQ-018 The block SHALL implement FSM states IDLE, FETCH, DECODE, UPDATE, HALT.
REQ-019 IDLE: all strobes 0, pc_ctl=00; start=1 -> FETCH next cycle.
REQ-020 FETCH: fetch_en=1 unless a halt is pending; stall=1 -> stay in FETCH; stall=0 -> DECODE; halt pending -> HALT with fetch_en=0.
REQ-021 DECODE: wait while op_valid=0; on op_valid=1 the block SHALL register op_kind and cond_true; op_kind=11 -> HALT (no PC update); otherwise -> UPDATE.
REQ-022 UPDATE: exactly one cycle with pc_latch_data=1; pc_ctl = 01 for kind 00, 10 for kind 01 with cond_true=1, 01 for kind 01 with cond_true=0, 11 for kind 10; then -> FETCH, or -> HALT if a halt is pending.
REQ-023 pc_ctl SHALL be 00 and pc_latch_data 0 in every state other than UPDATE.
REQ-024 The halt_req pulse SHALL set a pending flag in any state; the flag clears on entry to HALT; a pulse arriving in IDLE is ignored.
REQ-025 HALT: halted=1; start=1 with no halt_req in the same cycle -> FETCH, PC unchanged; start and halt_req in the same cycle -> remain in HALT.
REQ-026 Latency: start sampled high in IDLE -> fetch_en=1 on the following cycle; minimum instruction period is 3 cycles (FETCH, DECODE, UPDATE).
REQ-027 All outputs SHALL be registered or decoded from registered state only; no input-to-output combinational paths.

Reset
REQ-028 reset=0 SHALL force state IDLE, clear the halt-pending flag and registered op fields, and drive pc_ctl=00, pc_latch_data=0, fetch_en=0, branch_taken=0, busy=0, halted=0, instr_count=0.
REQ-029 Reset asserted mid-UPDATE SHALL drop pc_latch_data asynchronously; no partial PC update is signalled.
REQ-030 After reset deassertion the block SHALL remain in IDLE until start=1.

Configuration
REQ-031 Macro PC_SEQ_PERF_CNT_EN: when defined, instr_count SHALL increment by 1 on every UPDATE cycle, wrap from all-ones to 0, and hold otherwise; when undefined, instr_count SHALL be tied to 0 and no counter register instantiated.

Verification
REQ-032 Reset, start=1, op_kind=00 x5, stall=0, op_valid on first DECODE cycle -> 5 pulses of pc_latch_data with pc_ctl=01, 3 cycles apart; instr_count=5 with macro, 0 without.
REQ-033 op_kind=01 cond_true=1, then 01 with cond_true=0, then 10 -> pc_ctl 10, 01, 11 in successive UPDATEs; branch_taken 1, 0, 1.
REQ-034 stall=1 for 4 cycles in FETCH -> fetch_en held 4+1 cycles, no pc_latch_data, then normal DECODE.
REQ-035 halt_req pulse during DECODE -> current instruction's UPDATE completes, then HALT, halted=1; start=1 -> FETCH, pc_ctl=00 on entry.
REQ-036 Reset driven low mid-UPDATE, between clka edges -> pc_latch_data, busy and all other outputs 0 immediately; state IDLE after release.
REQ-037 PC_SEQ_PERF_CNT_EN defined, CNT_BITS=4, 17 sequential instructions -> instr_count wraps and reads 1.

Source files
------------

// File: rtl/pc_sequencer_if.sv
// -----------------------------------------------------------------------------
// pc_sequencer_if
// Purpose : bundles the control inputs and status/PC-control outputs of the
//           pc_sequencer block into one interface.
// Modports:
//   master - drives start, halt_req, stall, op_valid, op_kind, cond_true;
//            observes pc_ctl, pc_latch_data, fetch_en, branch_taken, busy,
//            halted, instr_count.
//   slave  - the sequencer side (directions mirrored).
// Parameter:
//   CNT_BITS - width of instr_count; must match the sequencer's CNT_BITS.
// -----------------------------------------------------------------------------
interface pc_sequencer_if #(
    parameter int CNT_BITS = 16
);
    logic                start;
    logic                halt_req;
    logic                stall;
    logic                op_valid;
    logic [1:0]          op_kind;
    logic                cond_true;
    logic [1:0]          pc_ctl;
    logic                pc_latch_data;
    logic                fetch_en;
    logic                branch_taken;
    logic                busy;
    logic                halted;
    logic [CNT_BITS-1:0] instr_count;

    modport master (
        output start, halt_req, stall, op_valid, op_kind, cond_true,
        input  pc_ctl, pc_latch_data, fetch_en, branch_taken, busy, halted,
               instr_count
    );

    modport slave (
        input  start, halt_req, stall, op_valid, op_kind, cond_true,
        output pc_ctl, pc_latch_data, fetch_en, branch_taken, busy, halted,
               instr_count
    );
endinterface

// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
// Purpose : instruction sequencer FSM (IDLE/FETCH/DECODE/UPDATE/HALT) that
//           generates PC source select and update strobe, instruction fetch
//           enable and status flags.
// Ports   :
//   clka   - system clock, rising edge
//   reset  - asynchronous, active-low reset
//   bus    - pc_sequencer_if.slave:
//              in : start, halt_req, stall, op_valid, op_kind[1:0], cond_true
//              out: pc_ctl[1:0], pc_latch_data, fetch_en, branch_taken, busy,
//                   halted, instr_count[CNT_BITS-1:0]
// Parameters:
//   PC_BITS  - width of the PC / branch-target fields being controlled
//   CNT_BITS - width of the retired-instruction counter
// Build option:
//   PC_SEQ_PERF_CNT_EN - when defined, instr_count counts UPDATE cycles
//                        (wrapping); otherwise it is constant 0 and no
//                        counter register exists.
// All outputs are decoded from registered state only.
// -----------------------------------------------------------------------------
module pc_sequencer #(
    parameter int PC_BITS  = 6,
    parameter int CNT_BITS = 16
) (
    input  logic          clka,
    input  logic          reset,
    pc_sequencer_if.slave bus
);

    localparam logic [1:0] PC_HOLD = 2'b00;
    localparam logic [1:0] PC_INC  = 2'b01;
    localparam logic [1:0] PC_IMM  = 2'b10;
    localparam logic [1:0] PC_SR1  = 2'b11;

    localparam logic [1:0] OP_SEQ  = 2'b00;
    localparam logic [1:0] OP_BR   = 2'b01;
    localparam logic [1:0] OP_JMP  = 2'b10;
    localparam logic [1:0] OP_HALT = 2'b11;

    // The sequencer only selects PC sources; the PC itself lives elsewhere.
    // Reject a degenerate PC width at elaboration time.
    if (PC_BITS < 1) begin : g_pc_bits_check
        $error("pc_sequencer: PC_BITS must be at least 1");
    end

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_UPDATE = 3'd3,
        ST_HALT   = 3'd4
    } state_t;

    state_t     r_state;
    state_t     w_state_next;
    logic       r_halt_pend;
    logic       w_halt_pend_next;
    logic [1:0] r_op_kind;
    logic       r_cond_true;
    logic       w_op_capture;

    logic [1:0] w_pc_ctl;
    logic       w_pc_latch_data;
    logic       w_fetch_en;
    logic       w_branch_taken;
    logic       w_busy;
    logic       w_halted;

    // ------------------------------------------------------------------
    // State, halt-pending flag and captured opcode fields
    // ------------------------------------------------------------------
    always_ff @(posedge clka or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_halt_pend <= 1'b0;
            r_op_kind   <= 2'b00;
            r_cond_true <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_halt_pend <= w_halt_pend_next;
            if (w_op_capture) begin
                r_op_kind   <= bus.op_kind;
                r_cond_true <= bus.cond_true;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic and state-decoded outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next    = r_state;
        w_op_capture    = 1'b0;
        w_pc_ctl        = PC_HOLD;
        w_pc_latch_data = 1'b0;
        w_fetch_en      = 1'b0;
        w_branch_taken  = 1'b0;
        w_busy          = 1'b0;
        w_halted        = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_state_next = ST_FETCH;
                end
            end

            ST_FETCH: begin
                w_busy     = 1'b1;
                // A pending halt suppresses the fetch and wins over stall.
                w_fetch_en = !r_halt_pend;
                if (r_halt_pend) begin
                    w_state_next = ST_HALT;
                end else if (!bus.stall) begin
                    w_state_next = ST_DECODE;
                end
            end

            ST_DECODE: begin
                w_busy = 1'b1;
                if (bus.op_valid) begin
                    w_op_capture = 1'b1;
                    // A halt opcode never reaches UPDATE, so the PC is untouched.
                    w_state_next = (bus.op_kind == OP_HALT) ? ST_HALT : ST_UPDATE;
                end
            end

            ST_UPDATE: begin
                w_busy          = 1'b1;
                w_pc_latch_data = 1'b1;
                case (r_op_kind)
                    OP_SEQ:  w_pc_ctl = PC_INC;
                    OP_BR:   w_pc_ctl = r_cond_true ? PC_IMM : PC_INC;
                    OP_JMP:  w_pc_ctl = PC_SR1;
                    default: w_pc_ctl = PC_INC;
                endcase
                w_branch_taken = w_pc_ctl[1];
                w_state_next   = r_halt_pend ? ST_HALT : ST_FETCH;
            end

            ST_HALT: begin
                w_halted = 1'b1;
                // A simultaneous halt request vetoes the resume.
                if (bus.start && !bus.halt_req) begin
                    w_state_next = ST_FETCH;
                end
            end

            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Halt-pending flag: cleared on entry to HALT (highest priority),
    // set by halt_req while sequencing. Requests in IDLE are ignored, and
    // in HALT the request is already satisfied so it is not re-armed.
    // ------------------------------------------------------------------
    always_comb begin
        w_halt_pend_next = r_halt_pend;
        if ((w_state_next == ST_HALT) && (r_state != ST_HALT)) begin
            w_halt_pend_next = 1'b0;
        end else if (bus.halt_req && (r_state != ST_IDLE) && (r_state != ST_HALT)) begin
            w_halt_pend_next = 1'b1;
        end
    end

    assign bus.pc_ctl        = w_pc_ctl;
    assign bus.pc_latch_data = w_pc_latch_data;
    assign bus.fetch_en      = w_fetch_en;
    assign bus.branch_taken  = w_branch_taken;
    assign bus.busy          = w_busy;
    assign bus.halted        = w_halted;

    // ------------------------------------------------------------------
    // Optional retired-instruction counter (one count per UPDATE cycle)
    // ------------------------------------------------------------------
`ifdef PC_SEQ_PERF_CNT_EN
    logic [CNT_BITS-1:0] r_instr_count;

    always_ff @(posedge clka or negedge reset) begin
        if (!reset) begin
            r_instr_count <= '0;
        end else if (r_state == ST_UPDATE) begin
            r_instr_count <= r_instr_count + CNT_BITS'(1);
        end
    end

    assign bus.instr_count = r_instr_count;
`else
    assign bus.instr_count = '0;
`endif

endmodule
